// File: rtl/psram_responder_if.sv
// 8-bit PSRAM bus bundle: chip select, serial clock and data both ways.
// The controller side is the master; the responder side is the slave.
interface psram_responder_if;
   logic       psram_csn;
   logic       psram_sclk;
   logic [7:0] psram_din;
   logic [7:0] psram_dout;
   logic       psram_oe;

   modport master (
      output psram_csn, psram_sclk, psram_din,
      input  psram_dout, psram_oe
   );

   modport slave (
      input  psram_csn, psram_sclk, psram_din,
      output psram_dout, psram_oe
   );
endinterface

// File: rtl/psram_responder.sv
// PSRAM device model on block RAM; decisions 3 i_clk after a bus edge, read data within 4 i_clk of a fall.
// No backpressure: the controller paces everything with sclk. Optional sticky error flag: PSRAM_RESPONDER_ERR_EN.
module psram_responder #(
   parameter int ADDR_W       = 10,
   parameter int DUMMY_CYCLES = 6
) (
   input  logic              i_clk,
   input  logic              i_rst,
   psram_responder_if.slave  bus,
   output logic [2:0]        o_state,
   output logic              o_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CMD    = 3'd1,
      S_ADDR   = 3'd2,
      S_DUMMY  = 3'd3,
      S_WDATA  = 3'd4,
      S_RDATA  = 3'd5,
      S_IGNORE = 3'd6
   } state_t;

   // Synchronizers run through reset so csn's true level is known the moment reset releases.
   logic       csn_s1_q, csn_s2_q, csn_s3_q;
   logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic [7:0] din_s1_q, din_s2_q;

   always_ff @(posedge i_clk) begin
      csn_s1_q  <= bus.psram_csn;
      csn_s2_q  <= csn_s1_q;
      csn_s3_q  <= csn_s2_q;
      sclk_s1_q <= bus.psram_sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      din_s1_q  <= bus.psram_din;
      din_s2_q  <= din_s1_q;
   end

   logic csn_fall, csn_rise, sclk_rise, sclk_fall;
   assign csn_fall  =  csn_s3_q  & ~csn_s2_q;
   assign csn_rise  = ~csn_s3_q  &  csn_s2_q;
   assign sclk_rise = ~sclk_s3_q &  sclk_s2_q;
   assign sclk_fall =  sclk_s3_q & ~sclk_s2_q;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        is_wr_q, is_wr_d;
   logic [23:0] addr_q, addr_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] shift_q, shift_d;
   logic        oe_q, oe_d;
   logic        armed_q, armed_d;

   logic [15:0]       mem_q [DEPTH];
   logic [15:0]       rdata_q;
   logic              mem_we;
   logic [15:0]       mem_wdata;
   logic [ADDR_W-1:0] word_addr, raddr;

   assign word_addr = addr_q[ADDR_W-1:0];
   // In RDATA the next word is prefetched continuously so it is ready at the low byte's fall.
   assign raddr     = (state_q == S_RDATA) ? word_addr + ADDR_W'(1) : word_addr;

   always_ff @(posedge i_clk) begin
      if (mem_we) mem_q[word_addr] <= mem_wdata;
      rdata_q <= mem_q[raddr];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      hi_d      = hi_q;
      shift_d   = shift_q;
      oe_d      = oe_q;
      armed_d   = armed_q;
      mem_we    = 1'b0;
      mem_wdata = {hi_q, din_s2_q};

      if (state_q != S_IDLE && csn_rise) begin
         state_d = S_IDLE;
         cnt_d   = 8'd0;
         shift_d = 16'd0;
         oe_d    = 1'b0;
         armed_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // csn low without a detected fall only happens when reset released mid-frame.
               if (!csn_s2_q) begin
                  state_d = csn_fall ? S_CMD : S_IGNORE;
                  cnt_d   = 8'd0;
               end
            end
            S_CMD: begin
               if (sclk_rise) begin
                  cnt_d = 8'd0;
                  if (din_s2_q == 8'h38) begin
                     state_d = S_ADDR;
                     is_wr_d = 1'b1;
                  end else if (din_s2_q == 8'hEB) begin
                     state_d = S_ADDR;
                     is_wr_d = 1'b0;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
            end
            S_ADDR: begin
               if (sclk_rise) begin
                  addr_d = {addr_q[15:0], din_s2_q};
                  if (cnt_q == 8'd2) begin
                     state_d = is_wr_q ? S_WDATA : S_DUMMY;
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            S_DUMMY: begin
               if (sclk_rise) begin
                  if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
                     state_d = S_RDATA;
                     shift_d = rdata_q;
                     oe_d    = 1'b1;
                     armed_d = 1'b0;
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            S_WDATA: begin
               if (sclk_rise) begin
                  if (!cnt_q[0]) begin
                     hi_d  = din_s2_q;
                     cnt_d = 8'd1;
                  end else begin
                     mem_we = 1'b1;
                     addr_d = {addr_q[23:ADDR_W], word_addr + ADDR_W'(1)};
                     cnt_d  = 8'd0;
                  end
               end
            end
            S_RDATA: begin
               // Only a fall that follows a data rise advances, so the first byte survives the
               // fall right after the last dummy rise.
               if (sclk_rise) begin
                  armed_d = 1'b1;
               end else if (sclk_fall && armed_q) begin
                  armed_d = 1'b0;
                  if (!cnt_q[0]) begin
                     shift_d = {shift_q[7:0], 8'h00};
                     cnt_d   = 8'd1;
                  end else begin
                     shift_d = rdata_q;
                     addr_d  = {addr_q[23:ADDR_W], word_addr + ADDR_W'(1)};
                     cnt_d   = 8'd0;
                  end
               end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         is_wr_q <= 1'b0;
         addr_q  <= 24'd0;
         hi_q    <= 8'd0;
         shift_q <= 16'd0;
         oe_q    <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         hi_q    <= hi_d;
         shift_q <= shift_d;
         oe_q    <= oe_d;
         armed_q <= armed_d;
      end
   end

   assign bus.psram_dout = shift_q[15:8];
   assign bus.psram_oe   = oe_q;
   assign o_state        = state_q;

`ifdef PSRAM_RESPONDER_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (csn_rise && (state_q == S_CMD || state_q == S_ADDR ||
                       (state_q == S_WDATA && cnt_q[0])))
         err_d = 1'b1;
      if (!csn_rise && state_q == S_CMD && sclk_rise &&
          din_s2_q != 8'h38 && din_s2_q != 8'hEB)
         err_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// Drives the PSRAM bus as a slow controller and checks reads against a word-array model of memory.
module tb_psram_responder;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
   localparam int H      = 4;   // sclk half-period in i_clk cycles
`ifdef PSRAM_RESPONDER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] state;
   logic       err;

   psram_responder_if bus();

   psram_responder #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(6)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .bus    (bus),
      .o_state(state),
      .o_err  (err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] model [DEPTH];
   bit          known [DEPTH];
   logic [15:0] wbuf [8];
   bit          exp_err = 1'b0;
   logic [23:0] addr_hist [$];
   int          len_hist [$];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put_byte(input logic [7:0] b);
      bus.psram_din = b;
      tick(H);
      bus.psram_sclk = 1'b1;
      tick(H);
      bus.psram_sclk = 1'b0;
   endtask

   task automatic get_byte(output logic [7:0] b);
      tick(H);
      bus.psram_sclk = 1'b1;
      b = bus.psram_dout;
      tick(H);
      bus.psram_sclk = 1'b0;
   endtask

   task automatic start_frame();
      bus.psram_csn = 1'b0;
      tick(H);
   endtask

   task automatic end_frame();
      tick(H);
      bus.psram_csn = 1'b1;
      tick(2 * H);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(4);
      rst = 1'b0;
      exp_err = 1'b0;
      tick(2);
   endtask

   task automatic write_words(input logic [23:0] a, input int n);
      start_frame();
      put_byte(8'h38);
      put_byte(a[23:16]);
      put_byte(a[15:8]);
      put_byte(a[7:0]);
      for (int i = 0; i < n; i++) begin
         put_byte(wbuf[i][15:8]);
         put_byte(wbuf[i][7:0]);
      end
      end_frame();
      for (int i = 0; i < n; i++) begin
         int idx;
         idx = (int'(a[ADDR_W-1:0]) + i) % DEPTH;
         model[idx] = wbuf[i];
         known[idx] = 1'b1;
      end
   endtask

   task automatic read_check(input logic [23:0] a, input int n, input string tag);
      logic [7:0] hi, lo;
      start_frame();
      put_byte(8'hEB);
      put_byte(a[23:16]);
      put_byte(a[15:8]);
      put_byte(a[7:0]);
      for (int i = 0; i < 6; i++) put_byte(8'($urandom));
      chk({tag, "_oe_on"}, 32'(bus.psram_oe), 32'd1);
      chk({tag, "_state_rd"}, 32'(state), 32'd5);
      for (int i = 0; i < n; i++) begin
         int idx;
         idx = (int'(a[ADDR_W-1:0]) + i) % DEPTH;
         get_byte(hi);
         get_byte(lo);
         if (known[idx]) chk($sformatf("%s_w%0d", tag, i), {16'd0, hi, lo}, {16'd0, model[idx]});
      end
      end_frame();
      chk({tag, "_oe_off"}, 32'(bus.psram_oe), 32'd0);
   endtask

   initial begin
      logic [23:0] ra;
      int          rn;

      bus.psram_csn  = 1'b1;
      bus.psram_sclk = 1'b0;
      bus.psram_din  = 8'h00;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

      tick(4);
      chk("rst_dout", 32'(bus.psram_dout), 32'd0);
      chk("rst_oe", 32'(bus.psram_oe), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick(2);

      wbuf[0] = 16'h1234;
      write_words(24'h000020, 1);

      // reset released with csn already low: the whole frame must be ignored
      bus.psram_csn = 1'b0;
      rst = 1'b1;
      tick(4);
      chk("csnlow_in_rst_state", 32'(state), 32'd0);
      rst = 1'b0;
      tick(3);
      chk("csnlow_state", 32'(state), 32'd6);
      put_byte(8'h38); put_byte(8'h00); put_byte(8'h00); put_byte(8'h20);
      put_byte(8'hAB); put_byte(8'hCD);
      chk("csnlow_hold_state", 32'(state), 32'd6);
      chk("csnlow_oe", 32'(bus.psram_oe), 32'd0);
      bus.psram_csn = 1'b1;
      tick(5);
      chk("csnlow_idle", 32'(state), 32'd0);
      chk("csnlow_err", 32'(err), 32'd0);
      read_check(24'h000020, 1, "csnlow_mem");

      wbuf[0] = 16'h8765;
      write_words(24'h000005, 1);
      read_check(24'h000005, 1, "basic");

      wbuf[0] = 16'hAABB;
      wbuf[1] = 16'hCCDD;
      write_words(24'h0003FF, 2);
      read_check(24'h0003FF, 2, "wrap");
      read_check(24'h000000, 1, "wrap0");
      read_check(24'h0407FF, 1, "alias");
      chk("wrap_err", 32'(err), 32'd0);

      for (int it = 0; it < 10; it++) begin
         ra = 24'($urandom);
         rn = $urandom_range(1, 4);
         for (int i = 0; i < rn; i++) wbuf[i] = 16'($urandom);
         write_words(ra, rn);
         addr_hist.push_back(ra);
         len_hist.push_back(rn);
         read_check(ra, rn, $sformatf("rnd%0d", it));
      end
      for (int it = 0; it < 10; it++) begin
         read_check(addr_hist[it], len_hist[it], $sformatf("reread%0d", it));
      end

      // partial word: csn rises after only the high byte
      wbuf[0] = 16'hBEEF;
      write_words(24'h000010, 1);
      start_frame();
      put_byte(8'h38); put_byte(8'h00); put_byte(8'h00); put_byte(8'h10);
      put_byte(8'h12);
      end_frame();
      exp_err = exp_err | ERR_EN;
      chk("partial_state", 32'(state), 32'd0);
      chk("partial_err", 32'(err), 32'(exp_err));
      read_check(24'h000010, 1, "partial_mem");
      chk("partial_err_sticky", 32'(err), 32'(exp_err));

      do_reset();
      chk("rst2_err", 32'(err), 32'd0);

      start_frame();
      put_byte(8'h5A);
      for (int i = 0; i < 6; i++) put_byte(8'($urandom));
      chk("badcmd_state", 32'(state), 32'd6);
      chk("badcmd_oe", 32'(bus.psram_oe), 32'd0);
      end_frame();
      exp_err = exp_err | ERR_EN;
      chk("badcmd_idle", 32'(state), 32'd0);
      chk("badcmd_err", 32'(err), 32'(exp_err));
      read_check(24'h000010, 1, "badcmd_mem");

      do_reset();
      wbuf[0] = 16'h5555;
      write_words(24'h000040, 1);
      chk("race_pre_err", 32'(err), 32'd0);
      start_frame();
      put_byte(8'h38); put_byte(8'h00); put_byte(8'h00); put_byte(8'h40);
      put_byte(8'h12);
      bus.psram_din = 8'h34;
      tick(H);
      bus.psram_sclk = 1'b1;
      bus.psram_csn  = 1'b1;
      tick(H);
      bus.psram_sclk = 1'b0;
      tick(2 * H);
      exp_err = exp_err | ERR_EN;
      chk("race_state", 32'(state), 32'd0);
      chk("race_err", 32'(err), 32'(exp_err));
      read_check(24'h000040, 1, "race_mem");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
